// File: rtl/mc_core.sv
// mc_core: multi-cycle RV32/RV64 integer core with req/ready instruction and data ports
// Ports: clk, rst_n (async, active-low); imem_req/addr/ready/rdata fetch port;
// dmem_req/we/addr/wdata/ready/rdata data port; pc current instruction address;
// retire one pulse per completed instruction; halted/illegal sticky stop flags.
module mc_core #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'('h80000000)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            halted,
  output logic            illegal
);
  localparam logic [2:0] LSF = (XLEN == 64) ? 3'b011 : 3'b010;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;
  state_t state, state_nxt;
  logic [31:0] ir;
  logic [XLEN-1:0] rf [32];
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd;
  logic [XLEN-1:0] rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [XLEN-1:0] pc4, sum_i, wd_alu, pc_tgt, rf_wd, pc_nxt;
  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_addi, is_add, is_sub;
  logic is_ld, is_st, is_ebreak, is_mem, legal, taken, rf_we, pc_we;
  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign f7  = ir[31:25];
  // rf[0] is cleared on reset and never written, so it reads as x0
  assign rs1_v = rf[ir[19:15]];
  assign rs2_v = rf[ir[24:20]];
  assign imm_i = XLEN'($signed(ir[31:20]));
  assign imm_s = XLEN'($signed({ir[31:25], ir[11:7]}));
  assign imm_b = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({ir[31:12], 12'b0}));
  assign is_lui    = opc == 7'b0110111;
  assign is_auipc  = opc == 7'b0010111;
  assign is_jal    = opc == 7'b1101111;
  assign is_jalr   = opc == 7'b1100111 && f3 == 3'b000;
  // funct3 with bit 1 clear selects BEQ/BNE/BLT/BGE
  assign is_br     = opc == 7'b1100011 && !f3[1];
  assign is_addi   = opc == 7'b0010011 && f3 == 3'b000;
  assign is_add    = opc == 7'b0110011 && f3 == 3'b000 && f7 == 7'h00;
  assign is_sub    = opc == 7'b0110011 && f3 == 3'b000 && f7 == 7'h20;
  assign is_ld     = opc == 7'b0000011 && f3 == LSF;
  assign is_st     = opc == 7'b0100011 && f3 == LSF;
  assign is_ebreak = ir == 32'h00100073;
  assign is_mem    = is_ld | is_st;
  assign legal     = is_lui | is_auipc | is_jal | is_jalr | is_br | is_addi | is_add | is_sub | is_mem;
  // funct3[2] picks signed-less-than over equality, funct3[0] inverts the sense
  assign taken  = is_br && ((f3[2] ? ($signed(rs1_v) < $signed(rs2_v)) : (rs1_v == rs2_v)) ^ f3[0]);
  assign pc4    = pc + XLEN'(4);
  assign sum_i  = rs1_v + imm_i;
  assign wd_alu = is_lui ? imm_u :
                  is_auipc ? pc + imm_u :
                  (is_jal | is_jalr) ? pc4 :
                  is_addi ? sum_i :
                  is_sub ? rs1_v - rs2_v : rs1_v + rs2_v;
  assign pc_tgt = is_jal ? pc + imm_j :
                  is_jalr ? {sum_i[XLEN-1:1], 1'b0} :
                  taken ? pc + imm_b : pc4;
  assign imem_addr  = pc;
  assign dmem_addr  = rs1_v + (is_st ? imm_s : imm_i);
  assign dmem_wdata = rs2_v;
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    retire    = 1'b0;
    rf_we     = 1'b0;
    rf_wd     = wd_alu;
    pc_we     = 1'b0;
    pc_nxt    = pc_tgt;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        imem_req  = 1'b1;
        state_nxt = imem_ready ? EXEC : FETCH;
      end
      EXEC: begin
        state_nxt = is_mem ? MEM : legal ? FETCH : HALT;
        retire    = legal && !is_mem;
        rf_we     = legal && !is_mem && !is_br;
        pc_we     = legal && !is_mem;
      end
      MEM: begin
        dmem_req  = 1'b1;
        dmem_we   = is_st;
        retire    = dmem_ready;
        rf_we     = dmem_ready && is_ld;
        rf_wd     = dmem_rdata;
        pc_we     = dmem_ready;
        pc_nxt    = pc4;
        state_nxt = dmem_ready ? FETCH : MEM;
      end
      default: state_nxt = HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      ir      <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (state == FETCH && imem_ready) ir <= imem_rdata;
      if (pc_we) pc <= pc_nxt;
      if (rf_we && rd != 5'd0) rf[rd] <= rf_wd;
      if (state == EXEC && !legal) begin
        halted  <= 1'b1;
        illegal <= !is_ebreak;
      end
    end
  end
endmodule

// File: tb/tb_mc_core.sv
// tb_mc_core: scoreboard bench for mc_core with XLEN=64 and zero/wait-state memories
module tb_mc_core;
  localparam int XLEN = 64;
  localparam logic [63:0] BASE = 64'h80000000;
  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } dx_t;
  logic clk, rst_n;
  logic imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted, illegal;
  logic [63:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, pc;
  logic [31:0] imem_rdata;
  logic [31:0] prog [16];
  logic [63:0] fq[$];
  dx_t dq[$];
  dx_t d;
  int checks = 0, failures = 0, ret_cnt = 0, iwait = 0, dwait = 0;
  logic ipend, dpend;
  logic [63:0] ihold, dhold_a, dhold_w, ld_data;
  mc_core #(.XLEN(XLEN), .RESET_PC(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .pc(pc), .retire(retire), .halted(halted), .illegal(illegal)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // one clock: respond to requests at the falling edge, then sample outputs
  task automatic tick();
    @(negedge clk);
    if (imem_req) begin
      if (ipend) check("imem_hold", imem_addr, ihold);
      if (iwait > 0) begin
        iwait--;
        imem_ready = 1'b0;
        ipend = 1'b1;
        ihold = imem_addr;
      end else begin
        imem_ready = 1'b1;
        ipend = 1'b0;
        imem_rdata = prog[imem_addr[5:2]];
        check("fetch_pending", 64'(fq.size() != 0), 1);
        if (fq.size() != 0) check("fetch_addr", imem_addr, fq.pop_front());
      end
    end else begin
      imem_ready = 1'b0;
      ipend = 1'b0;
    end
    if (dmem_req) begin
      if (dpend) begin
        check("dmem_hold_addr", dmem_addr, dhold_a);
        check("dmem_hold_wdata", dmem_wdata, dhold_w);
      end
      if (dwait > 0) begin
        dwait--;
        dmem_ready = 1'b0;
        dpend = 1'b1;
        dhold_a = dmem_addr;
        dhold_w = dmem_wdata;
      end else begin
        dmem_ready = 1'b1;
        dpend = 1'b0;
        dmem_rdata = ld_data;
        check("dmem_pending", 64'(dq.size() != 0), 1);
        if (dq.size() != 0) begin
          d = dq.pop_front();
          check("dmem_we", dmem_we, d.we);
          check("dmem_addr", dmem_addr, d.addr);
          if (d.we) check("dmem_wdata", dmem_wdata, d.wdata);
        end
      end
    end else begin
      dmem_ready = 1'b0;
      dpend = 1'b0;
    end
    #1;
    if (retire) ret_cnt++;
    if (halted) check("halt_quiet", {imem_req, dmem_req}, 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    iwait = 0;
    dwait = 0;
    ipend = 1'b0;
    dpend = 1'b0;
    ret_cnt = 0;
    fq.delete();
    dq.delete();
    for (int i = 0; i < 16; i++) prog[i] = 32'h00100073;
    @(negedge clk);
    check("rst_pc", pc, BASE);
    check("rst_ireq", imem_req, 0);
    check("rst_dreq", dmem_req, 0);
    check("rst_flags", {retire, halted, illegal, dmem_we}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic drained(input string tag);
    check({tag, "_fq"}, fq.size(), 0);
    check({tag, "_dq"}, dq.size(), 0);
  endtask
  initial begin
    rst_n = 1'b0;
    imem_rdata = '0;
    dmem_rdata = '0;
    ld_data = '0;
    // addi x1,x0,5; add x2,x1,x1; sd x2,8(x0); ebreak
    do_reset();
    prog[0] = 32'h00500093;
    prog[1] = 32'h00108133;
    prog[2] = 32'h00203423;
    for (int i = 0; i < 4; i++) fq.push_back(BASE + 64'(4 * i));
    dq.push_back('{we: 1'b1, addr: 64'd8, wdata: 64'd10});
    tick();
    check("idle_ireq", imem_req, 0);
    tick();
    check("first_ireq", imem_req, 1);
    check("first_iaddr", imem_addr, BASE);
    repeat (5) tick();
    check("ret_6cyc", ret_cnt, 2);
    tick();
    check("ret_7cyc", ret_cnt, 3);
    repeat (4) tick();
    check("prog1_halted", halted, 1);
    check("prog1_illegal", illegal, 0);
    check("prog1_ret", ret_cnt, 3);
    drained("prog1");
    // three fetch wait states on the first fetch
    do_reset();
    prog[0] = 32'h00500093;
    iwait = 3;
    fq.push_back(BASE);
    fq.push_back(BASE + 4);
    repeat (10) tick();
    check("wait_ret", ret_cnt, 1);
    check("wait_halted", halted, 1);
    drained("wait");
    // jal x1,8; bne x1,x0,+8 (taken); beq x0,x1,+8 (not taken); sd x1,0(x0)
    do_reset();
    prog[0] = 32'h008000ef;
    prog[2] = 32'h00009463;
    prog[4] = 32'h00100463;
    prog[5] = 32'h00103023;
    fq.push_back(BASE);
    fq.push_back(BASE + 8);
    fq.push_back(BASE + 16);
    fq.push_back(BASE + 20);
    fq.push_back(BASE + 24);
    dq.push_back('{we: 1'b1, addr: 64'd0, wdata: BASE + 4});
    repeat (20) tick();
    check("jmp_ret", ret_cnt, 4);
    check("jmp_halted", halted, 1);
    check("jmp_pc", pc, BASE + 24);
    drained("jmp");
    // ld x3,0(x0) with two data wait states; sd x3,16(x0); ebreak
    do_reset();
    prog[0] = 32'h00003183;
    prog[1] = 32'h00303823;
    ld_data = 64'hDEADBEEF00000001;
    dwait = 2;
    fq.push_back(BASE);
    fq.push_back(BASE + 4);
    fq.push_back(BASE + 8);
    dq.push_back('{we: 1'b0, addr: 64'd0, wdata: 64'd0});
    dq.push_back('{we: 1'b1, addr: 64'd16, wdata: 64'hDEADBEEF00000001});
    repeat (16) tick();
    check("ld_ret", ret_cnt, 2);
    check("ld_halted", halted, 1);
    check("ld_illegal", illegal, 0);
    drained("ld");
    ld_data = '0;
    // illegal encoding
    do_reset();
    prog[0] = 32'hFFFFFFFF;
    fq.push_back(BASE);
    repeat (6) tick();
    check("ill_illegal", illegal, 1);
    check("ill_halted", halted, 1);
    check("ill_ret", ret_cnt, 0);
    check("ill_pc", pc, BASE);
    drained("ill");
    // reset asserted while a load waits in MEM
    do_reset();
    prog[0] = 32'h00500093;
    prog[1] = 32'h00003183;
    dwait = 1000;
    fq.push_back(BASE);
    fq.push_back(BASE + 4);
    for (int n = 0; n < 20 && !dmem_req; n++) tick();
    check("mem_reached", dmem_req, 1);
    check("mem_pc", pc, BASE + 4);
    rst_n = 1'b0;
    #1;
    check("rstmem_dreq", dmem_req, 0);
    check("rstmem_pc", pc, BASE);
    dq.delete();
    dwait = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
